uart_fw_dump: RTL and testbench

// Bus-master firmware read-back/transmit engine; the sending end of the UART firmware-download protocol.

---
 rtl/uart_fw_dump.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_fw_dump.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fw_dump.sv
// Firmware read-back engine: reads a memory range, frames 35-byte CRC16/Modbus packets,
// pushes them through the memory-mapped UART and resends on NAK/timeout up to MAX_RETRY times.
//
// state        | meaning
// S_IDLE       | waiting for start_i
// S_INIT_CTRL  | writing CTRL=3
// S_INIT_BAUD  | writing BAUD=BAUD_DIV
// S_BUILD_HDR  | loading header payload (seq 0, length big-endian)
// S_CRC        | CRC over payload, one bit step per cycle
// S_TX_POLL    | reading STATUS until TX_BUSY clears
// S_TX_WR      | one-cycle write of the current byte to TX
// S_ACK_CLR    | writing STATUS=0 to clear RX_OVER
// S_ACK_POLL   | reading STATUS until RX_OVER or timeout
// S_ACK_RD     | reading RX byte
// S_ACK_EVAL   | ACK -> next packet / done, else resend or abort
// S_FETCH      | reading 8 payload words of the next data packet
// S_DONE       | done_o pulse
// S_ERR        | retry limit exhausted
module uart_fw_dump #(
   parameter int unsigned BAUD_DIV    = 434,
   parameter int unsigned MAX_RETRY   = 4,
   parameter int unsigned ACK_TIMEOUT = 5_000_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic [31:0] dump_len_i,
   output logic        req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);
   localparam logic [31:0] CTRL_ADDR   = 32'h3000_0000;
   localparam logic [31:0] STATUS_ADDR = 32'h3000_0004;
   localparam logic [31:0] BAUD_ADDR   = 32'h3000_0008;
   localparam logic [31:0] TX_ADDR     = 32'h3000_000C;
   localparam logic [31:0] RX_ADDR     = 32'h3000_0010;
   localparam logic [31:0] BAUD_C      = 32'(BAUD_DIV);
   localparam logic [7:0]  RETRY_C     = 8'(MAX_RETRY);
   localparam logic [31:0] TMO_C       = 32'(ACK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_CTRL, S_INIT_BAUD, S_BUILD_HDR, S_CRC, S_TX_POLL, S_TX_WR,
      S_ACK_CLR, S_ACK_POLL, S_ACK_RD, S_ACK_EVAL, S_FETCH, S_DONE, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0]   len_q, len_d, bytes_left_q, bytes_left_d, fetch_addr_q, fetch_addr_d;
   logic [31:0]   tmo_q, tmo_d;
   logic [27:0]   pkt_cnt_q, pkt_cnt_d, pkt_num_q, pkt_num_d;
   logic [7:0]    retry_q, retry_d, rx_q, rx_d;
   logic [255:0]  pay_q, pay_d;
   logic [15:0]   crc_q, crc_d;
   logic [5:0]    byte_idx_q, byte_idx_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [2:0]    word_idx_q, word_idx_d;
   logic          ph_q, ph_d;

   logic [4:0]    pidx;
   logic [7:0]    tx_byte, crc_in;
   logic [31:0]   rd_mask;
   logic          word_adv;

   always_comb begin
      pidx   = 5'(byte_idx_q - 6'd1);
      crc_in = pay_q[{byte_idx_q[4:0], 3'b000} +: 8];
      if (byte_idx_q == 6'd0)       tx_byte = pkt_num_q[7:0];
      else if (byte_idx_q <= 6'd32) tx_byte = pay_q[{pidx, 3'b000} +: 8];
      else if (byte_idx_q == 6'd33) tx_byte = crc_q[7:0];
      else                          tx_byte = crc_q[15:8];
      // trailing word of the dump keeps only bytes still inside dump_len
      case (bytes_left_q)
         32'd1:   rd_mask = 32'h0000_00FF;
         32'd2:   rd_mask = 32'h0000_FFFF;
         32'd3:   rd_mask = 32'h00FF_FFFF;
         default: rd_mask = 32'hFFFF_FFFF;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      done_d       = 1'b0;
      err_d        = err_q;
      len_d        = len_q;
      bytes_left_d = bytes_left_q;
      fetch_addr_d = fetch_addr_q;
      tmo_d        = tmo_q;
      pkt_cnt_d    = pkt_cnt_q;
      pkt_num_d    = pkt_num_q;
      retry_d      = retry_q;
      rx_d         = rx_q;
      pay_d        = pay_q;
      crc_d        = crc_q;
      byte_idx_d   = byte_idx_q;
      bit_idx_d    = bit_idx_q;
      word_idx_d   = word_idx_q;
      ph_d         = ph_q;
      word_adv     = 1'b0;

      case (state_q)
         S_IDLE: if (start_i) begin
            state_d      = S_INIT_CTRL;
            addr_d       = CTRL_ADDR;
            we_d         = 1'b1;
            wdata_d      = 32'd3;
            err_d        = 1'b0;
            len_d        = dump_len_i;
            bytes_left_d = dump_len_i;
            fetch_addr_d = base_addr_i;
            pkt_cnt_d    = {1'b0, dump_len_i[31:5]} + 28'd1;
            pkt_num_d    = '0;
            retry_d      = '0;
         end
         S_INIT_CTRL: begin
            state_d = S_INIT_BAUD;
            addr_d  = BAUD_ADDR;
            we_d    = 1'b1;
            wdata_d = BAUD_C;
         end
         S_INIT_BAUD: state_d = S_BUILD_HDR;
         S_BUILD_HDR: begin
            pay_d          = '0;
            pay_d[199:192] = len_q[31:24];
            pay_d[207:200] = len_q[23:16];
            pay_d[215:208] = len_q[15:8];
            pay_d[223:216] = len_q[7:0];
            crc_d          = 16'hFFFF;
            byte_idx_d     = '0;
            bit_idx_d      = '0;
            state_d        = S_CRC;
         end
         S_CRC: begin
            if (bit_idx_q == 4'd0) crc_d = crc_q ^ {8'h00, crc_in};
            else                   crc_d = {1'b0, crc_q[15:1]} ^ (crc_q[0] ? 16'hA001 : 16'h0000);
            if (bit_idx_q == 4'd8) begin
               bit_idx_d = '0;
               if (byte_idx_q == 6'd31) begin
                  byte_idx_d = '0;
                  state_d    = S_TX_POLL;
                  addr_d     = STATUS_ADDR;
               end else begin
                  byte_idx_d = byte_idx_q + 6'd1;
               end
            end else begin
               bit_idx_d = bit_idx_q + 4'd1;
            end
         end
         S_TX_POLL: if (!mem_rdata_i[0]) begin
            state_d = S_TX_WR;
            addr_d  = TX_ADDR;
            we_d    = 1'b1;
            wdata_d = {24'h0, tx_byte};
         end
         S_TX_WR: begin
            addr_d = STATUS_ADDR;
            if (byte_idx_q == 6'd34) begin
               byte_idx_d = '0;
               state_d    = S_ACK_CLR;
               we_d       = 1'b1;
               wdata_d    = '0;
            end else begin
               byte_idx_d = byte_idx_q + 6'd1;
               state_d    = S_TX_POLL;
            end
         end
         S_ACK_CLR: begin
            state_d = S_ACK_POLL;
            addr_d  = STATUS_ADDR;
            tmo_d   = TMO_C;
         end
         S_ACK_POLL: begin
            if (mem_rdata_i[1]) begin
               state_d = S_ACK_RD;
               addr_d  = RX_ADDR;
            end else if (tmo_q == 32'd0) begin
               rx_d    = 8'h15;
               state_d = S_ACK_EVAL;
            end else begin
               tmo_d = tmo_q - 32'd1;
            end
         end
         S_ACK_RD: begin
            rx_d    = mem_rdata_i[7:0];
            state_d = S_ACK_EVAL;
         end
         S_ACK_EVAL: begin
            if (rx_q == 8'h06) begin
               retry_d = '0;
               if (pkt_num_q == pkt_cnt_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  pkt_num_d  = pkt_num_q + 28'd1;
                  word_idx_d = '0;
                  ph_d       = 1'b0;
                  state_d    = S_FETCH;
               end
            end else if (retry_q == RETRY_C) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               // buffered payload and CRC are reused as-is for the resend
               retry_d    = retry_q + 8'd1;
               byte_idx_d = '0;
               state_d    = S_TX_POLL;
               addr_d     = STATUS_ADDR;
            end
         end
         S_FETCH: begin
            if (!ph_q) begin
               if (bytes_left_q != 32'd0) begin
                  addr_d = fetch_addr_q;
                  ph_d   = 1'b1;
               end else begin
                  pay_d[{word_idx_q, 5'b00000} +: 32] = '0;
                  word_adv = 1'b1;
               end
            end else begin
               pay_d[{word_idx_q, 5'b00000} +: 32] = mem_rdata_i & rd_mask;
               bytes_left_d = (bytes_left_q > 32'd4) ? bytes_left_q - 32'd4 : 32'd0;
               fetch_addr_d = fetch_addr_q + 32'd4;
               ph_d         = 1'b0;
               word_adv     = 1'b1;
            end
            if (word_adv) begin
               word_idx_d = word_idx_q + 3'd1;
               if (word_idx_q == 3'd7) begin
                  crc_d      = 16'hFFFF;
                  byte_idx_d = '0;
                  bit_idx_d  = '0;
                  state_d    = S_CRC;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
      req_d  = busy_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         len_q        <= '0;
         bytes_left_q <= '0;
         fetch_addr_q <= '0;
         tmo_q        <= '0;
         pkt_cnt_q    <= '0;
         pkt_num_q    <= '0;
         retry_q      <= '0;
         rx_q         <= '0;
         pay_q        <= '0;
         crc_q        <= '0;
         byte_idx_q   <= '0;
         bit_idx_q    <= '0;
         word_idx_q   <= '0;
         ph_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         we_q         <= we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         len_q        <= len_d;
         bytes_left_q <= bytes_left_d;
         fetch_addr_q <= fetch_addr_d;
         tmo_q        <= tmo_d;
         pkt_cnt_q    <= pkt_cnt_d;
         pkt_num_q    <= pkt_num_d;
         retry_q      <= retry_d;
         rx_q         <= rx_d;
         pay_q        <= pay_d;
         crc_q        <= crc_d;
         byte_idx_q   <= byte_idx_d;
         bit_idx_q    <= bit_idx_d;
         word_idx_q   <= word_idx_d;
         ph_q         <= ph_d;
      end
   end

   assign req_o       = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_uart_fw_dump.sv
// Directed bench for uart_fw_dump: models memory plus a UART with TX_BUSY/RX_OVER and a
// scripted responder, and checks the transmitted byte stream against hand-built packets.
module tb_uart_fw_dump;
   localparam logic [31:0] CTRL_A = 32'h3000_0000, STAT_A = 32'h3000_0004, BAUD_A = 32'h3000_0008;
   localparam logic [31:0] TX_A = 32'h3000_000C, RX_A = 32'h3000_0010;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] base = '0, len = '0;
   logic req, mem_we, busy, done, err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   uart_fw_dump dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .dump_len_i(len),
      .req_o(req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   // memory and responder script (written by the test sequence only)
   logic [31:0] mem_words [16];
   logic [31:0] mem_base = 32'h1000;
   logic [7:0]  resp_script [8];
   int          resp_len = 0, resp_start = 0;
   logic        bad_mode = 1'b0, force_busy = 1'b0;

   // UART model state (written by the monitor only)
   int busy_cnt = 0, resp_cnt = 0, resp_idx = 0, read_cnt = 0, done_cnt = 0, busy_viol = 0;
   logic rx_over = 1'b0, busy_at_edge = 1'b0, tx_busy;
   logic [7:0]  rx_byte = 8'h00;
   logic [31:0] prev_addr = '1, mem_off;
   logic [7:0]  tx_log [$];
   logic [31:0] wr_addr [$], wr_data [$];

   logic [7:0] exp_q [$];
   int checks = 0, fails = 0;

   assign tx_busy = force_busy | (busy_cnt != 0);
   assign mem_off = mem_addr - mem_base;

   always_comb begin
      if (mem_addr == STAT_A)    mem_rdata = {30'h0, rx_over, tx_busy};
      else if (mem_addr == RX_A) mem_rdata = {24'h0, rx_byte};
      else if (mem_addr >= mem_base && mem_off < 32'd64) mem_rdata = mem_words[mem_off[5:2]];
      else mem_rdata = 32'hDEAD_BEEF;
   end

   always @(posedge clk) busy_at_edge <= tx_busy;

   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0; resp_cnt = 0; rx_over = 1'b0; prev_addr = mem_addr;
      end else begin
         if (busy_cnt > 0) busy_cnt--;
         if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (mem_addr == TX_A) begin
               if (busy_at_edge) busy_viol++;
               tx_log.push_back(mem_wdata[7:0]);
               busy_cnt = 3;
            end
            if (mem_addr == STAT_A) begin
               rx_over = 1'b0;
               resp_cnt = 5;
            end
         end
         if (!mem_we && mem_addr < CTRL_A && mem_addr != prev_addr) read_cnt++;
         prev_addr = mem_addr;
         if (done) done_cnt++;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               rx_over = 1'b1;
               if (bad_mode) rx_byte = 8'h41;
               else if (resp_idx - resp_start < resp_len) rx_byte = resp_script[resp_idx - resp_start];
               else rx_byte = 8'h06;
               resp_idx++;
            end
         end
      end
   end

   function automatic logic [15:0] crc16(input logic [255:0] p);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         c = c ^ {8'h00, p[8*i +: 8]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   task automatic add_pkt(input logic [7:0] seq, input logic [255:0] p);
      logic [15:0] c;
      c = crc16(p);
      exp_q.push_back(seq);
      for (int i = 0; i < 32; i++) exp_q.push_back(p[8*i +: 8]);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
   endtask

   function automatic logic [255:0] hdr_payload(input logic [31:0] l);
      logic [255:0] p;
      p = '0;
      p[8*24 +: 8] = l[31:24];
      p[8*25 +: 8] = l[23:16];
      p[8*26 +: 8] = l[15:8];
      p[8*27 +: 8] = l[7:0];
      return p;
   endfunction

   function automatic int pkt_diff(input int t0, input int pk);
      int n, idx;
      n = 0;
      for (int b = 0; b < 35; b++) begin
         idx = t0 + pk * 35 + b;
         if (idx >= tx_log.size()) n++;
         else if (tx_log[idx] !== exp_q[pk * 35 + b]) n++;
      end
      return n;
   endfunction

   task automatic do_start(input logic [31:0] b, input logic [31:0] l);
      @(negedge clk);
      base = b; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (done || err) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_tx(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (tx_log.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic load_len8_mem();
      mem_base = 32'h1000;
      for (int i = 0; i < 16; i++) mem_words[i] = 32'hA5A5_A5A5;
      mem_words[0] = 32'h1122_3344;
      mem_words[1] = 32'h5566_7788;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (req !== 1'b0)       begin fails++; $display("FAIL reset_req: got %b want 0", req); end
      checks++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL reset_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_len8();
      int tx0, wr0, rd0, dn0; bit ok;
      load_len8_mem();
      exp_q.delete();
      add_pkt(8'h00, hdr_payload(32'd8));
      // pkt1 bytes 1..8: 44 33 22 11 88 77 66 55, rest zero
      add_pkt(8'h01, {192'h0, 64'h5566_7788_1122_3344});
      tx0 = tx_log.size(); wr0 = wr_addr.size(); rd0 = read_cnt; dn0 = done_cnt;
      resp_start = resp_idx; resp_len = 0;
      do_start(32'h1000, 32'd8);
      repeat (20) @(negedge clk);
      start = 1'b1; len = 32'd64; @(negedge clk); start = 1'b0;
      wait_end(ok);
      checks++; if (!ok) begin fails++; $display("FAIL len8_finish: got timeout want done"); end
      @(negedge clk);
      checks++; if (wr_addr.size() < wr0 + 2 || wr_addr[wr0] !== CTRL_A || wr_data[wr0] !== 32'd3)
         begin fails++; $display("FAIL len8_ctrl_init: first write not CTRL=3"); end
      checks++; if (wr_addr.size() < wr0 + 2 || wr_addr[wr0+1] !== BAUD_A || wr_data[wr0+1] !== 32'd434)
         begin fails++; $display("FAIL len8_baud_init: second write not BAUD=434"); end
      checks++; if (tx_log.size() - tx0 != 70) begin fails++; $display("FAIL len8_tx_count: got %0d want 70", tx_log.size() - tx0); end
      checks++; if (pkt_diff(tx0, 0) != 0) begin fails++; $display("FAIL len8_hdr: %0d bytes differ want 0", pkt_diff(tx0, 0)); end
      checks++; if (pkt_diff(tx0, 1) != 0) begin fails++; $display("FAIL len8_pkt1: %0d bytes differ want 0", pkt_diff(tx0, 1)); end
      checks++; if (done_cnt - dn0 != 1) begin fails++; $display("FAIL len8_done_cnt: got %0d want 1", done_cnt - dn0); end
      checks++; if (read_cnt - rd0 != 2) begin fails++; $display("FAIL len8_reads: got %0d want 2", read_cnt - rd0); end
      checks++; if (busy !== 1'b0 || req !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL len8_idle: busy/req/err got %b%b%b want 000", busy, req, err); end
   endtask

   task automatic test_len32();
      int tx0, rd0, dn0; bit ok; logic [255:0] p;
      mem_base = 32'h2000;
      for (int i = 0; i < 16; i++) mem_words[i] = 32'hA5A5_A5A5;
      for (int i = 0; i < 8; i++) mem_words[i] = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      for (int n = 0; n < 32; n++) p[8*n +: 8] = 8'(n + 1);
      exp_q.delete();
      add_pkt(8'h00, hdr_payload(32'd32));
      add_pkt(8'h01, p);
      add_pkt(8'h02, 256'h0);
      tx0 = tx_log.size(); rd0 = read_cnt; dn0 = done_cnt;
      resp_start = resp_idx; resp_len = 0;
      do_start(32'h2000, 32'd32);
      wait_end(ok);
      checks++; if (!ok) begin fails++; $display("FAIL len32_finish: got timeout want done"); end
      @(negedge clk);
      checks++; if (tx_log.size() - tx0 != 105) begin fails++; $display("FAIL len32_tx_count: got %0d want 105", tx_log.size() - tx0); end
      checks++; if (pkt_diff(tx0, 1) != 0) begin fails++; $display("FAIL len32_pkt1: %0d bytes differ want 0", pkt_diff(tx0, 1)); end
      checks++; if (pkt_diff(tx0, 2) != 0) begin fails++; $display("FAIL len32_pkt2_pad: %0d bytes differ want 0", pkt_diff(tx0, 2)); end
      checks++; if (read_cnt - rd0 != 8) begin fails++; $display("FAIL len32_reads: got %0d want 8", read_cnt - rd0); end
      checks++; if (done_cnt - dn0 != 1) begin fails++; $display("FAIL len32_done_cnt: got %0d want 1", done_cnt - dn0); end
   endtask

   task automatic test_nak();
      int tx0, rd0, dn0; bit ok;
      load_len8_mem();
      exp_q.delete();
      add_pkt(8'h00, hdr_payload(32'd8));
      for (int k = 0; k < 3; k++) add_pkt(8'h01, {192'h0, 64'h5566_7788_1122_3344});
      tx0 = tx_log.size(); rd0 = read_cnt; dn0 = done_cnt;
      resp_script[0] = 8'h06; resp_script[1] = 8'h15; resp_script[2] = 8'h15;
      resp_start = resp_idx; resp_len = 3;
      do_start(32'h1000, 32'd8);
      wait_end(ok);
      checks++; if (!ok) begin fails++; $display("FAIL nak_finish: got timeout want done"); end
      @(negedge clk);
      resp_len = 0;
      checks++; if (tx_log.size() - tx0 != 140) begin fails++; $display("FAIL nak_tx_count: got %0d want 140", tx_log.size() - tx0); end
      for (int k = 1; k < 4; k++) begin
         checks++; if (pkt_diff(tx0, k) != 0) begin fails++; $display("FAIL nak_resend%0d: %0d bytes differ want 0", k, pkt_diff(tx0, k)); end
      end
      checks++; if (read_cnt - rd0 != 2) begin fails++; $display("FAIL nak_reads: got %0d want 2", read_cnt - rd0); end
      checks++; if (done_cnt - dn0 != 1 || err !== 1'b0) begin fails++; $display("FAIL nak_done: done_cnt %0d err %b want 1 0", done_cnt - dn0, err); end
   endtask

   task automatic test_retry_abort();
      int tx0, dn0; bit ok;
      load_len8_mem();
      exp_q.delete();
      for (int k = 0; k < 5; k++) add_pkt(8'h00, hdr_payload(32'd8));
      tx0 = tx_log.size(); dn0 = done_cnt;
      bad_mode = 1'b1;
      do_start(32'h1000, 32'd8);
      wait_end(ok);
      checks++; if (!ok || err !== 1'b1) begin fails++; $display("FAIL abort_err: got ok=%b err=%b want 1 1", ok, err); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk);
      bad_mode = 1'b0;
      checks++; if (err !== 1'b1 || req !== 1'b0) begin fails++; $display("FAIL abort_sticky: err %b req %b want 1 0", err, req); end
      checks++; if (done_cnt - dn0 != 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - dn0); end
      checks++; if (tx_log.size() - tx0 != 175) begin fails++; $display("FAIL abort_tx_count: got %0d want 175", tx_log.size() - tx0); end
      checks++; if (pkt_diff(tx0, 4) != 0) begin fails++; $display("FAIL abort_last_hdr: %0d bytes differ want 0", pkt_diff(tx0, 4)); end
   endtask

   task automatic test_tx_busy();
      int tx0, v0, dn0, n_hold; bit ok;
      load_len8_mem();
      exp_q.delete();
      add_pkt(8'h00, hdr_payload(32'd8));
      add_pkt(8'h01, {192'h0, 64'h5566_7788_1122_3344});
      tx0 = tx_log.size(); v0 = busy_viol; dn0 = done_cnt;
      resp_start = resp_idx; resp_len = 0;
      do_start(32'h1000, 32'd8);
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL busy_err_cleared: got %b want 0", err); end
      wait_tx(tx0 + 10, ok);
      checks++; if (!ok) begin fails++; $display("FAIL busy_reach_byte10: got timeout want 10 bytes"); end
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      n_hold = tx_log.size();
      repeat (98) @(negedge clk);
      checks++; if (tx_log.size() != n_hold) begin fails++; $display("FAIL busy_hold: got %0d writes want 0", tx_log.size() - n_hold); end
      force_busy = 1'b0;
      wait_end(ok);
      checks++; if (!ok) begin fails++; $display("FAIL busy_finish: got timeout want done"); end
      @(negedge clk);
      checks++; if (busy_viol - v0 != 0) begin fails++; $display("FAIL busy_violation: got %0d want 0", busy_viol - v0); end
      checks++; if (pkt_diff(tx0, 0) != 0 || pkt_diff(tx0, 1) != 0) begin fails++; $display("FAIL busy_stream: %0d/%0d bytes differ want 0", pkt_diff(tx0, 0), pkt_diff(tx0, 1)); end
      checks++; if (done_cnt - dn0 != 1) begin fails++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt - dn0); end
   endtask

   task automatic test_reset_mid();
      int tx0, wr_n, rd0, dn0; bit ok;
      mem_base = 32'h2000;
      for (int i = 0; i < 8; i++) mem_words[i] = 32'hCAFE_0000 + 32'(i);
      tx0 = tx_log.size();
      resp_start = resp_idx; resp_len = 0;
      do_start(32'h2000, 32'd32);
      wait_tx(tx0 + 45, ok);
      checks++; if (!ok) begin fails++; $display("FAIL rstmid_reach_payload: got timeout want 45 bytes"); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({req, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
         begin fails++; $display("FAIL rstmid_outputs: req/we/busy/done/err %b addr %h wdata %h want all 0", {req, mem_we, busy, done, err}, mem_addr, mem_wdata); end
      wr_n = wr_addr.size();
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (wr_addr.size() != wr_n) begin fails++; $display("FAIL rstmid_no_writes: got %0d want 0", wr_addr.size() - wr_n); end
      load_len8_mem();
      exp_q.delete();
      add_pkt(8'h00, hdr_payload(32'd6));
      // len 6 keeps 44 33 22 11 88 77 and zeroes the rest of word 1
      add_pkt(8'h01, {208'h0, 48'h7788_1122_3344});
      tx0 = tx_log.size(); rd0 = read_cnt; dn0 = done_cnt;
      resp_start = resp_idx;
      do_start(32'h1000, 32'd6);
      wait_end(ok);
      checks++; if (!ok) begin fails++; $display("FAIL rstmid_restart: got timeout want done"); end
      @(negedge clk);
      checks++; if (wr_addr.size() <= wr_n || wr_addr[wr_n] !== CTRL_A || wr_data[wr_n] !== 32'd3)
         begin fails++; $display("FAIL rstmid_ctrl_first: first write after restart not CTRL=3"); end
      checks++; if (pkt_diff(tx0, 0) != 0 || pkt_diff(tx0, 1) != 0) begin fails++; $display("FAIL rstmid_len6_stream: %0d/%0d bytes differ want 0", pkt_diff(tx0, 0), pkt_diff(tx0, 1)); end
      checks++; if (read_cnt - rd0 != 2) begin fails++; $display("FAIL rstmid_len6_reads: got %0d want 2", read_cnt - rd0); end
      checks++; if (done_cnt - dn0 != 1) begin fails++; $display("FAIL rstmid_done_cnt: got %0d want 1", done_cnt - dn0); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem_words[i] = '0;
      for (int i = 0; i < 8; i++) resp_script[i] = 8'h06;
      test_reset();
      test_len8();
      test_len32();
      test_nak();
      test_retry_abort();
      test_tx_busy();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
